// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_share_ctrl
// Brief    : Round-robin sequencer time-sharing one external combinational
//            6-bit divider among NREQ requesters. Optional macro
//            DIV_ZERO_CHECK_EN short-circuits divide-by-zero with err_o.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_ctrl #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [6*NREQ-1:0] a_i,
    input  logic [6*NREQ-1:0] b_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   done_o,
    output logic [5:0]        q_o,
    output logic [5:0]        r_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [5:0]        div_a_o,
    output logic [5:0]        div_b_o,
    input  logic [5:0]        div_q_i,
    input  logic [5:0]        div_r_i
);

    localparam int           PW            = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]   c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] c_PTR_RESET  = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic [5:0]      r_q;
    logic [5:0]      r_r;
    logic [5:0]      r_div_a;
    logic [5:0]      r_div_b;
`ifdef DIV_ZERO_CHECK_EN
    logic            r_err;
    logic            r_zero;
`endif

    logic [5:0]      w_a_arr [NREQ];
    logic [5:0]      w_b_arr [NREQ];
    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_cand;
    logic [NREQ-1:0] w_win_oh;
    logic [5:0]      w_sel_a;
    logic [5:0]      w_sel_b;

    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_unpack
            assign w_a_arr[k] = a_i[6*k +: 6];
            assign w_b_arr[k] = b_i[6*k +: 6];
        end
    endgenerate

    // Search upward from the last winner so the previous owner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = PW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh = c_ONE << w_win;
    assign w_sel_a  = w_a_arr[w_win];
    assign w_sel_b  = w_b_arr[w_win];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= c_PTR_RESET;
            r_grant <= '0;
            r_done  <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
`ifdef DIV_ZERO_CHECK_EN
            r_err   <= 1'b0;
            r_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win_oh;
                        r_div_a <= w_sel_a;
                        r_div_b <= w_sel_b;
                        r_ptr   <= w_win;
                        r_state <= SETTLE;
`ifdef DIV_ZERO_CHECK_EN
                        // Zero divisor needs no settle time: finish on the next edge.
                        if (w_sel_b == 6'd0) begin
                            r_zero <= 1'b1;
                            r_cnt  <= 4'd0;
                        end else begin
                            r_zero <= 1'b0;
                            r_cnt  <= c_SETTLE_LOAD;
                        end
`else
                        r_cnt   <= c_SETTLE_LOAD;
`endif
                    end
                end
                SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_done  <= r_grant;
                        r_state <= DONE;
`ifdef DIV_ZERO_CHECK_EN
                        if (r_zero) begin
                            r_q   <= 6'h3F;
                            r_r   <= r_div_a;
                            r_err <= 1'b1;
                        end else begin
                            r_q   <= div_q_i;
                            r_r   <= div_r_i;
                            r_err <= 1'b0;
                        end
`else
                        r_q     <= div_q_i;
                        r_r     <= div_r_i;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = r_grant;
    assign done_o  = r_done;
    assign q_o     = r_q;
    assign r_o     = r_r;
    assign busy_o  = (r_state != IDLE);
    assign div_a_o = r_div_a;
    assign div_b_o = r_div_b;
`ifdef DIV_ZERO_CHECK_EN
    assign err_o   = r_err;
`else
    assign err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_ctrl
// Brief    : Self-checking bench for div_share_ctrl with an external divider
//            model and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;

    localparam int NREQ = 4;
    localparam int SC   = 3;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_i;
    logic [6*NREQ-1:0] a_i;
    logic [6*NREQ-1:0] b_i;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   done_o;
    logic [5:0]        q_o;
    logic [5:0]        r_o;
    logic              err_o;
    logic              busy_o;
    logic [5:0]        div_a_o;
    logic [5:0]        div_b_o;
    logic [5:0]        div_q_i;
    logic [5:0]        div_r_i;

    logic [5:0] opa [NREQ];
    logic [5:0] opb [NREQ];

    int tests = 0;
    int fails = 0;
    int ptr   = NREQ - 1;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        a_i = '0;
        b_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_i[6*k +: 6] = opa[k];
            b_i[6*k +: 6] = opb[k];
        end
    end

    // External combinational divider; a zero divisor yields all-ones / dividend.
    assign div_q_i = (div_b_o == 6'd0) ? 6'h3F : div_a_o / div_b_o;
    assign div_r_i = (div_b_o == 6'd0) ? div_a_o : div_a_o % div_b_o;

    div_share_ctrl #(.NREQ(NREQ), .SETTLE_CYCLES(SC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .grant_o (grant_o),
        .done_o  (done_o),
        .q_o     (q_o),
        .r_o     (r_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .div_a_o (div_a_o),
        .div_b_o (div_b_o),
        .div_q_i (div_q_i),
        .div_r_i (div_r_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m);
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (ptr + i) % NREQ;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    // Waits for the next grant, checks the whole transaction against the model.
    task automatic serve(input int exp_w, input bit early_drop, output int done_cyc);
        int n;
        int lat;
        logic [5:0] ea, eb, eq, er;
        bit ez;
        if (exp_w < 0) exp_w = pick(req_i);
        ea = opa[exp_w];
        eb = opb[exp_w];
        ez = (eb == 6'd0);
        eq = ez ? 6'h3F : ea / eb;
        er = ez ? ea : ea % eb;
        n = 0;
        while (grant_o == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant", grant_o, 32'(1) << exp_w);
        chk("busy_hi", busy_o, 1);
        chk("div_a", div_a_o, ea);
        chk("div_b", div_b_o, eb);
        if (early_drop) req_i[exp_w] = 1'b0;
        lat = 0;
        while (done_o == '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (ZCHK && ez) ? 1 : SC);
        chk("done", done_o, 32'(1) << exp_w);
        chk("q", q_o, eq);
        chk("r", r_o, er);
        chk("err", err_o, (ZCHK && ez) ? 1 : 0);
        done_cyc = cyc;
        ptr = exp_w;
        req_i[exp_w] = 1'b0;
        @(negedge clk);
        chk("done_clr", done_o, 0);
        chk("grant_clr", grant_o, 0);
        chk("busy_lo", busy_o, 0);
        chk("q_hold", q_o, eq);
        chk("r_hold", r_o, er);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_q"}, q_o, 0);
        chk({tag, "_r"}, r_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_diva"}, div_a_o, 0);
        chk({tag, "_divb"}, div_b_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr = NREQ - 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, prev, n;
        req_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_init");
        rst = 1'b0;
        ptr = NREQ - 1;
        @(negedge clk);

        // Single request: 45 / 7
        opa[0] = 6'd45; opb[0] = 6'd7; req_i = 4'b0001;
        serve(0, 1'b0, d);

        // All four from reset: 60 / (k+2), served 0,1,2,3 at fixed spacing
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = 6'd60;
            opb[k] = 6'(k + 2);
        end
        req_i = 4'b1111;
        prev = 0;
        for (int k = 0; k < NREQ; k++) begin
            serve(k, 1'b0, d);
            if (k > 0) chk("spacing", d - prev, SC + 2);
            prev = d;
        end

        // Wrap fairness: after 3 served, 0 beats 3, then 3
        opa[0] = 6'd20; opb[0] = 6'd3;
        opa[3] = 6'd40; opb[3] = 6'd9;
        req_i = 4'b1001;
        serve(0, 1'b0, d);
        serve(3, 1'b0, d);

        // Divide by zero
        opa[1] = 6'd17; opb[1] = 6'd0; req_i = 4'b0010;
        serve(1, 1'b0, d);

        // Boundaries
        opa[2] = 6'd63; opb[2] = 6'd1;  req_i = 4'b0100; serve(2, 1'b0, d);
        opa[2] = 6'd5;  opb[2] = 6'd63; req_i = 4'b0100; serve(2, 1'b0, d);
        opa[2] = 6'd0;  opb[2] = 6'd9;  req_i = 4'b0100; serve(2, 1'b0, d);

        // Requester drops early: operation still completes
        opa[1] = 6'd33; opb[1] = 6'd4; req_i = 4'b0010;
        serve(1, 1'b1, d);

        // Reset in the middle of SETTLE with req2 held
        opa[2] = 6'd50; opb[2] = 6'd6; req_i = 4'b0100;
        n = 0;
        while (grant_o == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_granted", grant_o, 4'b0100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        ptr = NREQ - 1;
        serve(2, 1'b0, d);

        // Randomized traffic against the round-robin model
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_i[k] && ($urandom_range(1, 0) == 1)) begin
                    opa[k] = 6'($urandom_range(63, 0));
                    opb[k] = ($urandom_range(7, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                    req_i[k] = 1'b1;
                end
            end
            if (req_i == '0) begin
                opa[t % NREQ] = 6'($urandom_range(63, 0));
                opb[t % NREQ] = 6'($urandom_range(63, 0));
                req_i[t % NREQ] = 1'b1;
            end
            serve(-1, ($urandom_range(7, 0) == 0), d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
